// File: rtl/bus_arbiter_if.sv
// Arbiter-facing bundle: DMA request/grant, CPU data-port handshake, burst status.
// Latency: none (signal bundle only).
// Backpressure: bg/cpu_stall carry the arbiter's hold-off back to DMA and CPU.
interface bus_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  // Requester side (DMA controller and CPU data port)
  logic                 br;
  logic                 mem_access_done;
  logic                 cpu_mem_req;
  logic                 cpu_mem_done;

  // Arbiter side
  logic                 bg;
  logic                 cpu_stall;
  logic [3:0]           beat_idx;
  logic                 dma_abort;
  logic [WORD_SIZE-1:0] burst_count;

  // The arbiter itself
  modport master (
    input  br,
    input  mem_access_done,
    input  cpu_mem_req,
    input  cpu_mem_done,
    output bg,
    output cpu_stall,
    output beat_idx,
    output dma_abort,
    output burst_count
  );

  // The requesters (DMA controller + CPU data port) seen from outside
  modport slave (
    output br,
    output mem_access_done,
    output cpu_mem_req,
    output cpu_mem_done,
    input  bg,
    input  cpu_stall,
    input  beat_idx,
    input  dma_abort,
    input  burst_count
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shared data-memory port arbiter between CPU data path and DMA block bursts.
// Latency: br/cpu_mem_req sampled in IDLE take effect after one edge (bg or stall release).
// Backpressure: DMA waits on bg; CPU held via cpu_stall while it does not own the port.
module bus_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int CPU_WINDOW  = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    GRANT    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // Beat index of the final word of a burst and the post-burst CPU window length
  localparam logic [3:0] LP_LAST_BEAT = 4'(BLOCK_WORDS - 1);
  localparam logic [3:0] LP_WINDOW    = 4'(CPU_WINDOW);
  localparam logic [WORD_SIZE-1:0] LP_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic                 r_bg;
  logic                 r_abort;
  logic [3:0]           r_beat;
  logic [3:0]           r_win;
  logic [WORD_SIZE-1:0] r_burst_count;

  logic                 w_last_beat;
  logic                 w_burst_sat;
  logic                 w_cpu_stall;

  assign w_last_beat = (r_beat == LP_LAST_BEAT);
  assign w_burst_sat = &r_burst_count;

  // Arbitration FSM with registered grant, abort pulse, beat index, burst count and window
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_bg          <= 1'b0;
      r_abort       <= 1'b0;
      r_beat        <= 4'd0;
      r_win         <= 4'd0;
      r_burst_count <= '0;
    end else begin
      // Abort is a single-cycle pulse; only the GRANT abort path re-arms it
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          // DMA wins a tie with a simultaneous CPU request
          if (bus.br) begin
            r_state <= GRANT;
            r_bg    <= 1'b1;
          end else if (bus.cpu_mem_req) begin
            r_state <= CPU_OWN;
          end
        end

        CPU_OWN: begin
          // A CPU access runs to completion; a pending br is served right after
          if (bus.cpu_mem_done) begin
            if (bus.br) begin
              r_state <= GRANT;
              r_bg    <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        GRANT: begin
          if (bus.mem_access_done) begin
            if (w_last_beat) begin
              // Final beat completes the burst even if br dropped this same cycle
              r_beat  <= 4'd0;
              r_state <= COOLDOWN;
              r_bg    <= 1'b0;
              r_win   <= LP_WINDOW;
              if (!w_burst_sat) begin
                r_burst_count <= r_burst_count + LP_ONE;
              end
            end else begin
              r_beat <= r_beat + 4'd1;
            end
          end else if (!bus.br) begin
            // Request withdrawn mid-burst: flag it and hand the bus back
            r_abort <= 1'b1;
            r_beat  <= 4'd0;
            r_state <= COOLDOWN;
            r_bg    <= 1'b0;
            r_win   <= LP_WINDOW;
          end
        end

        COOLDOWN: begin
          // CPU gets first claim; br is deliberately not looked at here
          if (bus.cpu_mem_req) begin
            r_state <= CPU_OWN;
            r_win   <= 4'd0;
          end else if (r_win <= 4'd1) begin
            // Counter expiring this cycle; a zero-length window still spends one cycle here
            r_state <= IDLE;
            r_win   <= 4'd0;
          end else begin
            r_win <= r_win - 4'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_bg    <= 1'b0;
        end
      endcase
    end
  end

  // CPU is held whenever it asks for the port but does not own it
  assign w_cpu_stall = bus.cpu_mem_req & (r_state != CPU_OWN);

  assign bus.bg          = r_bg;
  assign bus.cpu_stall   = w_cpu_stall;
  assign bus.beat_idx    = r_beat;
  assign bus.dma_abort   = r_abort;
  assign bus.burst_count = r_burst_count;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed table-driven bench for bus_arbiter plus hand sequences for reset and saturation.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a (bench drives all requester inputs directly).
module tb_bus_arbiter;

  logic clk;
  logic rst;

  bus_arbiter_if #(.WORD_SIZE(16)) bus ();
  bus_arbiter_if #(.WORD_SIZE(4))  bus2 ();

  bus_arbiter #(
    .WORD_SIZE  (16),
    .BLOCK_WORDS(4),
    .CPU_WINDOW (2)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.master)
  );

  // Narrow counter, single-beat bursts and no CPU window: exercises saturation quickly
  bus_arbiter #(
    .WORD_SIZE  (4),
    .BLOCK_WORDS(1),
    .CPU_WINDOW (0)
  ) dut2 (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        mad;
    logic        creq;
    logic        cdone;
    logic        bg;
    logic        stall;
    logic [3:0]  beat;
    logic        abort;
    logic [15:0] burst;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;

  function automatic vec_t mk(input logic br, input logic mad, input logic creq,
                              input logic cdone, input logic bg, input logic stall,
                              input logic [3:0] beat, input logic abort,
                              input logic [15:0] burst);
    vec_t v;
    v.br = br; v.mad = mad; v.creq = creq; v.cdone = cdone;
    v.bg = bg; v.stall = stall; v.beat = beat; v.abort = abort; v.burst = burst;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic br, input logic mad, input logic creq, input logic cdone);
    bus.br              = br;
    bus.mem_access_done = mad;
    bus.cpu_mem_req     = creq;
    bus.cpu_mem_done    = cdone;
  endtask

  task automatic step(input logic br, input logic mad, input logic creq, input logic cdone);
    drive(br, mad, creq, cdone);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".bg"},    {15'd0, bus.bg},        {15'd0, v.bg});
    check({tag, ".stall"}, {15'd0, bus.cpu_stall}, {15'd0, v.stall});
    check({tag, ".beat"},  {12'd0, bus.beat_idx},  {12'd0, v.beat});
    check({tag, ".abort"}, {15'd0, bus.dma_abort}, {15'd0, v.abort});
    check({tag, ".burst"}, bus.burst_count,        v.burst);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            br mad creq cdone | bg stall beat abort burst
    // Basic burst; br drops together with the final beat (normal completion)
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 1,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 1,0,0,0,0));
    vecs.push_back(mk(1,1,0,0, 1,0,1,0,0));
    vecs.push_back(mk(1,0,0,0, 1,0,1,0,0));
    vecs.push_back(mk(1,1,0,0, 1,0,2,0,0));
    vecs.push_back(mk(1,0,0,0, 1,0,2,0,0));
    vecs.push_back(mk(1,1,0,0, 1,0,3,0,0));
    vecs.push_back(mk(0,1,0,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0, 0,0,0,0,1));   // beat outside GRANT ignored
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,1));
    // Simultaneous br + cpu_mem_req: DMA first, CPU admitted in first cooldown cycle
    vecs.push_back(mk(1,0,1,0, 1,1,0,0,1));
    vecs.push_back(mk(1,1,1,0, 1,1,1,0,1));
    vecs.push_back(mk(1,1,1,0, 1,1,2,0,1));
    vecs.push_back(mk(1,1,1,0, 1,1,3,0,1));
    vecs.push_back(mk(1,1,1,0, 0,1,0,0,2));
    vecs.push_back(mk(1,0,1,0, 0,0,0,0,2));   // br ignored in cooldown, CPU owns
    vecs.push_back(mk(0,0,1,0, 0,0,0,0,2));
    vecs.push_back(mk(0,0,1,1, 0,1,0,0,2));   // done -> IDLE, req still up => stall
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,2));
    // CPU not pre-empted by br
    vecs.push_back(mk(0,0,1,0, 0,0,0,0,2));
    vecs.push_back(mk(0,0,1,0, 0,0,0,0,2));
    vecs.push_back(mk(1,0,1,0, 0,0,0,0,2));
    vecs.push_back(mk(1,1,1,0, 0,0,0,0,2));   // beat outside GRANT ignored
    vecs.push_back(mk(1,0,0,1, 1,0,0,0,2));   // grant right after CPU completes
    // Abort after two beats
    vecs.push_back(mk(1,1,0,0, 1,0,1,0,2));
    vecs.push_back(mk(1,1,0,0, 1,0,2,0,2));
    vecs.push_back(mk(0,0,0,0, 0,0,0,1,2));
    vecs.push_back(mk(0,0,0,1, 0,0,0,0,2));   // done outside CPU_OWN ignored
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,2));
    // Back-to-back bursts with br held: two cooldown cycles, IDLE, then re-grant
    vecs.push_back(mk(1,0,0,0, 1,0,0,0,2));
    vecs.push_back(mk(1,1,0,0, 1,0,1,0,2));
    vecs.push_back(mk(1,1,0,0, 1,0,2,0,2));
    vecs.push_back(mk(1,1,0,0, 1,0,3,0,2));
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,3));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,3));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,3));
    vecs.push_back(mk(1,0,0,0, 1,0,0,0,3));
    vecs.push_back(mk(1,1,0,0, 1,0,1,0,3));
    vecs.push_back(mk(1,1,0,0, 1,0,2,0,3));
    vecs.push_back(mk(1,1,0,0, 1,0,3,0,3));
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,4));

    bus2.br              = 1'b0;
    bus2.mem_access_done = 1'b0;
    bus2.cpu_mem_req     = 1'b0;
    bus2.cpu_mem_done    = 1'b0;

    // Reset with a CPU request pending: outputs cleared, stall follows the request
    rst = 1'b1;
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    check_all("reset", mk(0,0,0,0, 0,1,0,0,0));
    check("reset.burst2", {12'd0, bus2.burst_count}, 16'd0);
    rst = 1'b0;

    // CPU admission from IDLE: stalled for exactly the cycle before the edge
    drive(0, 0, 1, 0);
    #1;
    check("admit.pre_stall", {15'd0, bus.cpu_stall}, 16'd1);
    step(0, 0, 1, 0);
    check("admit.post_stall", {15'd0, bus.cpu_stall}, 16'd0);
    step(0, 0, 0, 1);
    check("admit.release_bg", {15'd0, bus.bg}, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].br, vecs[i].mad, vecs[i].creq, vecs[i].cdone);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-burst at beat 2: everything drops, no abort pulse follows
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rstmid.bg_up", {15'd0, bus.bg}, 16'd1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("rstmid.beat2", {12'd0, bus.beat_idx}, 16'd2);
    rst = 1'b1;
    step(1, 0, 0, 0);
    check_all("rstmid.reset", mk(0,0,0,0, 0,0,0,0,0));
    rst = 1'b0;
    step(0, 0, 0, 0);
    check_all("rstmid.after", mk(0,0,0,0, 0,0,0,0,0));

    // Saturation on the narrow instance: 3-cycle burst period, count tops out at 4'hF
    step(0, 0, 0, 0);
    bus2.br              = 1'b1;
    bus2.mem_access_done = 1'b1;
    for (int k = 1; k <= 47; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        check("sat.first", {12'd0, bus2.burst_count}, 16'd1);
      end
      if (k == 43) begin
        check("sat.pre14", {12'd0, bus2.burst_count}, 16'd14);
        check("sat.bg43",  {15'd0, bus2.bg},          16'd1);
      end
      if (k == 44) begin
        check("sat.full",  {12'd0, bus2.burst_count}, 16'd15);
        check("sat.bg44",  {15'd0, bus2.bg},          16'd0);
      end
      if (k == 46) begin
        check("sat.bg46",  {15'd0, bus2.bg},          16'd1);
      end
      if (k == 47) begin
        check("sat.hold",  {12'd0, bus2.burst_count}, 16'd15);
      end
    end
    bus2.br              = 1'b0;
    bus2.mem_access_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Owns the shared data-memory port (the 64-bit `data2` / `address2` bus) and decides, cycle by cycle, whether the CPU data path or the DMA controller drives it. It answers the DMA controller's bus request (`BR`) with a grant (`BG`) and holds the grant for one full block transfer. It stalls the CPU data port while the DMA owns the bus. After every burst it reserves a short CPU-priority window so a back-to-back DMA cannot starve the CPU. It sits between the CPU, the DMA controller and the memory mux, and drives the select that today is hard-wired to `BG`.

## Interface
- WORD_SIZE, 16, data-path word width; used for the burst counter width.
- BLOCK_WORDS, 4, number of `mem_access_done` beats in one DMA burst (1..15).
- CPU_WINDOW, 2, cycles after a burst during which a new `br` is not granted (0..15; 0 disables the window).

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- br  in  1  DMA bus request (level); held until the burst completes.
- mem_access_done  in  1  one-cycle pulse per completed DMA word beat.
- cpu_mem_req  in  1  CPU data-port access pending (`readM2 | writeM2`, level).
- cpu_mem_done  in  1  one-cycle pulse when the CPU access completes.
- bg  out  1  bus grant to DMA; also the memory-side mux select.
- cpu_stall  out  1  CPU data port must hold its request.
- beat_idx  out  4  index of the current DMA beat, 0..BLOCK_WORDS-1.
- dma_abort  out  1  one-cycle pulse: `br` dropped before BLOCK_WORDS beats.
- burst_count  out  WORD_SIZE  completed bursts; saturates at all-ones.

## Operation
- States: IDLE, CPU_OWN, GRANT, COOLDOWN. Reset state is IDLE.
- IDLE:
  - `br` = 1 → GRANT. The DMA has priority over a simultaneous `cpu_mem_req`.
  - Otherwise `cpu_mem_req` = 1 → CPU_OWN.
  - Otherwise stay in IDLE.
- CPU_OWN: hold until `cpu_mem_done`.
  - On `cpu_mem_done`: → GRANT if `br` = 1, else → IDLE.
  - A CPU access is never pre-empted by `br`.
- GRANT:
  - `bg` = 1.
  - Each `mem_access_done` increments `beat_idx`.
  - On the beat that makes the count equal BLOCK_WORDS: `beat_idx` clears to 0, `burst_count` increments (saturating) and the state → COOLDOWN.
  - `br` = 0 with the count below BLOCK_WORDS and no `mem_access_done` in that cycle: pulse `dma_abort`, clear `beat_idx`, → COOLDOWN. `burst_count` does not change.
  - `br` = 0 in the same cycle as the final beat is a normal completion, not an abort.
- COOLDOWN:
  - A down-counter loads CPU_WINDOW on entry.
  - `br` is ignored.
  - `cpu_mem_req` = 1 → CPU_OWN, and the window counter is discarded.
  - Counter reaches 0 → IDLE.
  - With CPU_WINDOW = 0, COOLDOWN lasts exactly one cycle and then goes to IDLE.
- `cpu_stall` = `cpu_mem_req` & (state ≠ CPU_OWN). This is combinational from the registered state.
- `bg` = (state == GRANT), decoded from the registered state.
- `mem_access_done` outside GRANT is ignored and does not change `beat_idx`.
- `cpu_mem_done` outside CPU_OWN is ignored.

## Timing
- Reset: while `reset` is high at a rising edge, all of the following take effect on that edge:
  - State is IDLE.
  - `bg`, `dma_abort`, `beat_idx` and `burst_count` are 0.
  - The window counter is 0.
  - `cpu_stall` follows `cpu_mem_req` (the state is not CPU_OWN).
- Reset mid-burst drops `bg` on the next edge, with no `dma_abort` pulse.
- Grant latency: `br` sampled high at edge N in IDLE → `bg` high after edge N (visible in cycle N+1).
- Release: final beat sampled at edge M → `bg` low after edge M.
- `burst_count` updates on the same edge M.
- CPU admission: from IDLE, `cpu_mem_req` sampled at edge N → `cpu_stall` low after edge N. This is exactly one stall cycle.
- `dma_abort` is high for exactly one cycle, the cycle after the edge that detects the abort.
- `beat_idx` changes only on edges where `mem_access_done` is sampled in GRANT.

## Test plan
- Basic burst, BLOCK_WORDS = 4, CPU_WINDOW = 2:
  - Stimulus: `br` high at cycle 3, four `mem_access_done` pulses at cycles 6, 8, 10, 12.
  - `bg` is high for cycles 4..12.
  - `beat_idx` reads 1, 2, 3, then 0.
  - `burst_count` = 1.
  - COOLDOWN covers cycles 13–14, then IDLE.
- Simultaneous request: `br` and `cpu_mem_req` both rise in IDLE.
  - `bg` goes high next cycle and `cpu_stall` stays 1 through the whole burst.
  - The CPU enters CPU_OWN in the first COOLDOWN cycle, so `cpu_stall` goes to 0 one cycle later.
- CPU not pre-empted:
  - Stimulus: `cpu_mem_req` accepted, then `br` rises two cycles later, then `cpu_mem_done` fires at cycle 7.
  - `bg` stays low through cycle 7 and is high from cycle 8.
- Back-to-back DMA: `br` held high across the end of a burst.
  - No grant during the 2 COOLDOWN cycles.
  - `bg` is re-asserted in the cycle after IDLE is reached.
  - `burst_count` goes to 2 after the second burst.
- Abort: `br` drops after 2 beats.
  - `dma_abort` pulses once.
  - `bg` is low the next cycle.
  - `beat_idx` = 0 and `burst_count` is unchanged.
- Reset mid-burst, then saturation:
  - `reset` at beat 2 gives all outputs 0 after the edge.
  - Separately, with `burst_count` preloaded by running 65535 bursts, or using a test-only force, one more burst leaves it at 0xFFFF.
